// File: rtl/ysyx_22050039_mem_arbiter_if.sv
// Bus bundle between IFU/LSU requesters, the arbiter and the pmem port.
// The arbiter uses the slave view; the other side uses the master view.
interface ysyx_22050039_mem_arbiter_if #(
    parameter int XLEN = 64
);
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_req_addr;
    logic            ifu_resp_valid;
    logic [XLEN-1:0] ifu_resp_data;
    logic            ifu_resp_err;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic [XLEN-1:0] lsu_req_addr;
    logic            lsu_req_wen;
    logic [XLEN-1:0] lsu_req_wdata;
    logic [7:0]      lsu_req_wmask;
    logic            lsu_resp_valid;
    logic [XLEN-1:0] lsu_resp_data;
    logic            lsu_resp_err;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_req_addr;
    logic            mem_req_wen;
    logic [XLEN-1:0] mem_req_wdata;
    logic [7:0]      mem_req_wmask;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_resp_data;

    logic            busy;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output busy
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data, ifu_resp_err,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data, lsu_resp_err,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  busy
    );
endinterface

// File: rtl/ysyx_22050039_mem_arbiter.sv
// Single-outstanding pmem arbiter: LSU-priority with an IFU starvation guard,
// per-owner response routing and a timeout that turns a hung memory into an error.
module ysyx_22050039_mem_arbiter #(
    parameter int XLEN          = 64,
    parameter int MAX_LSU_BURST = 4,
    parameter int TIMEOUT       = 255
) (
    input logic                        clk,
    input logic                        rst,
    ysyx_22050039_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_LSU_BURST + 2);
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   lsu_streak;
    logic [TW-1:0]   timer;
    logic            owner_lsu;
    logic            err;
    logic [XLEN-1:0] addr, wdata, rdata;
    logic            wen;
    logic [7:0]      wmask;
    logic            lsu_win, ifu_win, timeout;

    assign lsu_win = bus.lsu_req_valid &&
                     !(bus.ifu_req_valid && lsu_streak == SW'(MAX_LSU_BURST));
    assign ifu_win = bus.ifu_req_valid && !lsu_win;
    assign timeout = (timer == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        bus.ifu_req_ready = 1'b0;
        bus.lsu_req_ready = 1'b0;
        case (state)
            IDLE: if (!rst) begin
                bus.lsu_req_ready = lsu_win;
                bus.ifu_req_ready = ifu_win;
                if (lsu_win || ifu_win) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (timeout)                state_nxt = DONE;
                else if (bus.mem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (timeout || bus.mem_resp_valid) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_streak <= '0;
            timer      <= '0;
            owner_lsu  <= 1'b0;
            err        <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            rdata      <= '0;
            wen        <= 1'b0;
            wmask      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    err   <= 1'b0;
                    rdata <= '0;
                    if (!bus.ifu_req_valid) lsu_streak <= '0;
                    if (lsu_win) begin
                        addr      <= bus.lsu_req_addr;
                        wen       <= bus.lsu_req_wen;
                        wdata     <= bus.lsu_req_wdata;
                        wmask     <= bus.lsu_req_wmask;
                        owner_lsu <= 1'b1;
                        if (bus.ifu_req_valid && lsu_streak != SW'(MAX_LSU_BURST))
                            lsu_streak <= lsu_streak + 1'b1;
                    end else if (ifu_win) begin
                        addr       <= bus.ifu_req_addr;
                        wen        <= 1'b0;
                        wdata      <= '0;
                        wmask      <= '0;
                        owner_lsu  <= 1'b0;
                        lsu_streak <= '0;
                    end
                end
                ISSUE, WAIT: begin
                    timer <= timer + 1'b1;
                    // Timeout wins over a same-cycle ack so the error path is deterministic.
                    if (timeout) begin
                        err   <= 1'b1;
                        rdata <= '0;
                    end else if (state == WAIT && bus.mem_resp_valid) begin
                        rdata <= wen ? '0 : bus.mem_resp_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control outputs are masked while rst is high so an abandoned transaction never leaks a pulse.
    assign bus.busy           = !rst && state != IDLE;
    assign bus.mem_req_valid  = !rst && state == ISSUE;
    assign bus.mem_req_addr   = addr;
    assign bus.mem_req_wen    = wen;
    assign bus.mem_req_wdata  = wdata;
    assign bus.mem_req_wmask  = wmask;

    assign bus.ifu_resp_valid = !rst && state == DONE && !owner_lsu;
    assign bus.lsu_resp_valid = !rst && state == DONE &&  owner_lsu;
    assign bus.ifu_resp_data  = bus.ifu_resp_valid ? rdata : '0;
    assign bus.lsu_resp_data  = bus.lsu_resp_valid ? rdata : '0;
    assign bus.ifu_resp_err   = bus.ifu_resp_valid && err;
    assign bus.lsu_resp_err   = bus.lsu_resp_valid && err;
endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Bench for the pmem arbiter: vector table plus hand sequences for contention and
// reset-in-flight, with request and response scoreboards fed at grant time.
module tb_ysyx_22050039_mem_arbiter;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22050039_mem_arbiter_if #(.XLEN(XLEN)) bus ();

    ysyx_22050039_mem_arbiter #(
        .XLEN(XLEN), .MAX_LSU_BURST(4), .TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        bit          lsu;
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] mdata;
        int          rdy;
        int          rsp;
        bit          hang;
        logic [63:0] exp_data;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        bit          wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        bit          lsu;
        logic [63:0] data;
        bit          err;
    } rsp_t;

    req_t rq[$];
    rsp_t sb[$];

    int checks = 0, errors = 0;
    int cyc = 0, acc_cyc = 0, resp_cyc = 0;
    int rdy_delay = 0, rsp_delay = 0, last_run = 0;
    bit never_ack = 1'b0, stray_resp = 1'b0;
    logic [63:0] mem_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: ready after rdy_delay valid cycles, response rsp_delay cycles later.
    initial begin : mem_model
        int   phase, cnt, vrun;
        req_t r;
        phase = 0; cnt = 0; vrun = 0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            if (rst) begin
                phase = 0; cnt = 0; vrun = 0;
            end else if (stray_resp) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = 64'hbad0_bad0_bad0_bad0;
            end else if (phase == 0) begin
                if (bus.mem_req_valid) begin
                    vrun++;
                    if (rq.size() != 0) chk("req_addr_stable", bus.mem_req_addr, rq[0].addr);
                    if (!never_ack) begin
                        if (cnt == rdy_delay) begin
                            bus.mem_req_ready = 1'b1;
                            last_run = vrun;
                            vrun = 0; cnt = 0; phase = 1;
                            if (rq.size() != 0) begin
                                r = rq.pop_front();
                                chk("req_wen", bus.mem_req_wen, r.wen);
                                chk("req_wmask", bus.mem_req_wmask, r.wmask);
                                if (r.wen) chk("req_wdata", bus.mem_req_wdata, r.wdata);
                            end
                        end else cnt++;
                    end
                end else begin
                    vrun = 0; cnt = 0;
                end
            end else begin
                if (cnt == rsp_delay) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_data  = mem_data;
                    phase = 0; cnt = 0;
                end else cnt++;
            end
        end
    end

    // Response monitor: pops the scoreboard on every response pulse.
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
                resp_cyc = cyc;
                chk("resp_both_valid", 64'(bus.ifu_resp_valid & bus.lsu_resp_valid), 64'd0);
                chk("resp_mem_valid_low", 64'(bus.mem_req_valid), 64'd0);
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected actual=ifu%0d/lsu%0d expected=none (cycle %0d)",
                             bus.ifu_resp_valid, bus.lsu_resp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner_lsu", 64'(bus.lsu_resp_valid), 64'(e.lsu));
                    chk("resp_data", e.lsu ? bus.lsu_resp_data : bus.ifu_resp_data, e.data);
                    chk("resp_err", 64'(e.lsu ? bus.lsu_resp_err : bus.ifu_resp_err), 64'(e.err));
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int   n;
        req_t r;
        rsp_t s;
        rdy_delay = v.rdy; rsp_delay = v.rsp; mem_data = v.mdata; never_ack = v.hang;
        r.addr = v.addr; r.wen = v.lsu && v.wen; r.wdata = v.wdata;
        r.wmask = v.lsu ? v.wmask : 8'h00;
        if (!v.hang) rq.push_back(r);
        if (v.lsu) begin
            bus.lsu_req_addr = v.addr; bus.lsu_req_wen = v.wen;
            bus.lsu_req_wdata = v.wdata; bus.lsu_req_wmask = v.wmask;
            bus.lsu_req_valid = 1'b1;
        end else begin
            bus.ifu_req_addr = v.addr; bus.ifu_req_valid = 1'b1;
        end
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(v.lsu ? bus.lsu_req_ready : bus.ifu_req_ready) && n < 50);
        chk("grant_ready", 64'(v.lsu ? bus.lsu_req_ready : bus.ifu_req_ready), 64'd1);
        chk("grant_loser_ready", 64'(v.lsu ? bus.ifu_req_ready : bus.lsu_req_ready), 64'd0);
        acc_cyc = cyc;
        s.lsu = v.lsu; s.data = v.exp_data; s.err = v.exp_err;
        sb.push_back(s);
        @(posedge clk); #1;
        bus.lsu_req_valid = 1'b0; bus.ifu_req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk("resp_seen", 64'(sb.size()), 64'd0);
        chk("latency", 64'(resp_cyc - acc_cyc), v.hang ? 64'd257 : 64'(3 + v.rdy + v.rsp));
        if (!v.hang) chk("req_valid_run", 64'(last_run), 64'(v.rdy + 1));
        never_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t vecs[7];

    initial begin : main
        int   n;
        bit   el;
        req_t r;
        rsp_t s;
        vecs[0] = '{lsu:0, addr:64'h80000000, wen:0, wdata:0, wmask:0, mdata:64'h00000297_00000413,
                    rdy:0, rsp:0, hang:0, exp_data:64'h00000297_00000413, exp_err:0};
        vecs[1] = '{lsu:1, addr:64'h80001008, wen:1, wdata:64'hdeadbeef, wmask:8'h0f, mdata:64'h1234,
                    rdy:0, rsp:0, hang:0, exp_data:64'h0, exp_err:0};
        vecs[2] = '{lsu:1, addr:64'h80001010, wen:0, wdata:0, wmask:0, mdata:64'hcafebabe_0badf00d,
                    rdy:1, rsp:2, hang:0, exp_data:64'hcafebabe_0badf00d, exp_err:0};
        vecs[3] = '{lsu:0, addr:64'h80000004, wen:0, wdata:0, wmask:0, mdata:64'h13,
                    rdy:10, rsp:0, hang:0, exp_data:64'h13, exp_err:0};
        vecs[4] = '{lsu:1, addr:64'h80002000, wen:0, wdata:0, wmask:0, mdata:64'h5555,
                    rdy:0, rsp:0, hang:1, exp_data:64'h0, exp_err:1};
        vecs[5] = '{lsu:0, addr:64'h80000008, wen:0, wdata:0, wmask:0, mdata:64'h00100073,
                    rdy:0, rsp:0, hang:0, exp_data:64'h00100073, exp_err:0};
        vecs[6] = '{lsu:1, addr:64'h80001ff8, wen:1, wdata:64'h01234567_89abcdef, wmask:8'hff,
                    mdata:64'h7777, rdy:2, rsp:3, hang:0, exp_data:64'h0, exp_err:0};

        bus.ifu_req_valid = 0; bus.ifu_req_addr = 0;
        bus.lsu_req_valid = 0; bus.lsu_req_addr = 0; bus.lsu_req_wen = 0;
        bus.lsu_req_wdata = 0; bus.lsu_req_wmask = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ready", 64'({bus.ifu_req_ready, bus.lsu_req_ready}), 64'd0);
        chk("rst_mem_valid", 64'(bus.mem_req_valid), 64'd0);
        chk("rst_mem_addr", bus.mem_req_addr, 64'd0);
        chk("rst_mem_wmask", 64'(bus.mem_req_wmask), 64'd0);
        chk("rst_resp", 64'({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_err, bus.lsu_resp_err}), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Contention: grants follow L,L,L,L,I then the streak restarts.
        rdy_delay = 0; rsp_delay = 0; mem_data = 64'h1111_2222_3333_4444;
        bus.ifu_req_addr = 64'h80000100;
        bus.lsu_req_addr = 64'h80003000; bus.lsu_req_wen = 0; bus.lsu_req_wmask = 0;
        bus.ifu_req_valid = 1; bus.lsu_req_valid = 1;
        for (int g = 0; g < 10; g++) begin
            el = !(g == 4 || g == 9);
            n = 0;
            do begin @(negedge clk); n++; end
            while (!(bus.ifu_req_ready || bus.lsu_req_ready) && n < 20);
            chk($sformatf("contend_lsu_grant%0d", g), 64'(bus.lsu_req_ready), 64'(el));
            chk($sformatf("contend_ifu_grant%0d", g), 64'(bus.ifu_req_ready), 64'(!el));
            r.addr = el ? 64'h80003000 : 64'h80000100; r.wen = 0; r.wdata = 0; r.wmask = 0;
            rq.push_back(r);
            s.lsu = el; s.data = 64'h1111_2222_3333_4444; s.err = 0;
            sb.push_back(s);
            @(posedge clk); #1;
        end
        bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("contend_drain", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Reset while waiting on memory: the transaction vanishes without a response.
        rdy_delay = 0; rsp_delay = 20;
        bus.lsu_req_addr = 64'h80004000; bus.lsu_req_wen = 0; bus.lsu_req_valid = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.lsu_req_ready && n < 20);
        @(posedge clk); #1 bus.lsu_req_valid = 0;
        repeat (4) @(negedge clk);
        chk("rstwait_busy_before", 64'(bus.busy), 64'd1);
        chk("rstwait_in_wait", 64'(bus.mem_req_valid), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstwait_busy_after", 64'(bus.busy), 64'd0);
        stray_resp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stray_resp_busy", 64'(bus.busy), 64'd0);
        end
        stray_resp = 1'b0;
        @(posedge clk); #1;
        run_vec(vecs[2]);
        run_vec(vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
